// File: rtl/mux_2_pkg.sv
// Shared constants and select encoding for the registered 2:1 selector.
package mux_2_pkg;

  localparam int unsigned MUX_2_WIDTH_DEF = 1;
  localparam int unsigned MUX_2_CNT_W_DEF = 8;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_e;

endpackage

// File: rtl/mux_2_sat_cnt.sv
// Saturating up-counter: advances on inc, holds at all-ones, clears on synchronous reset.
module mux_2_sat_cnt
  import mux_2_pkg::*;
#(
  parameter int unsigned CNT_W = MUX_2_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_max;

  assign at_max = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !at_max) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mux_2_unit.sv
// Registered 2:1 selector. Define MUX_2_SEL_CNT_EN to add the saturating
// select-transition counter and its sel_cnt port.
module mux_2_unit
  import mux_2_pkg::*;
#(
  parameter int unsigned WIDTH = MUX_2_WIDTH_DEF,
  parameter int unsigned CNT_W = MUX_2_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
`ifdef MUX_2_SEL_CNT_EN
  output logic [CNT_W-1:0] sel_cnt,
`endif
  output logic [WIDTH-1:0] y
);

  sel_e             sel;
  logic [WIDTH-1:0] y_q, y_d;

  assign sel = sel_e'(c);

  always_comb begin
    y_d = a;
    if (sel == SEL_B) begin
      y_d = b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

`ifdef MUX_2_SEL_CNT_EN
  logic c_q;
  logic sel_toggle;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q <= 1'b0;
    end else begin
      c_q <= c;
    end
  end

  // c_q resets to 0, so a first post-reset c=1 counts as a transition.
  assign sel_toggle = (c != c_q);

  mux_2_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_sel_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (sel_toggle),
    .cnt  (sel_cnt)
  );
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_mux_2_unit.sv
// Directed bench for mux_2_unit: a 1-bit and an 8-bit instance share select and reset.
module tb_mux_2_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       c;
  logic       a1, b1, y1;
  logic [7:0] a8, b8, y8;
`ifdef MUX_2_SEL_CNT_EN
  logic [3:0] cnt1;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       y1;
    logic [7:0] y8;
    logic [3:0] cnt;
    string      tag;
  } exp_t;

  exp_t sb[$];

  logic [3:0] m_cnt;
  logic       m_cq;
  logic [7:0] truth;

  always #5 clk = ~clk;

  mux_2_unit #(
    .WIDTH(1),
    .CNT_W(4)
  ) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a1),
    .b      (b1),
    .c      (c),
`ifdef MUX_2_SEL_CNT_EN
    .sel_cnt(cnt1),
`endif
    .y      (y1)
  );

  mux_2_unit #(
    .WIDTH(8),
    .CNT_W(4)
  ) u_dut8 (
    .clk    (clk),
`ifdef MUX_2_SEL_CNT_EN
    .sel_cnt(),
`endif
    .rst_n  (rst_n),
    .a      (a8),
    .b      (b8),
    .c      (c),
    .y      (y8)
  );

  task automatic step(input logic a_in, input logic b_in, input logic c_in, input logic rst_in,
                      input logic exp_y1, input string tag);
    exp_t e;
    a1    = a_in;
    b1    = b_in;
    c     = c_in;
    rst_n = rst_in;
    a8    = 8'hA5;
    b8    = 8'h3C;
    if (!rst_in) begin
      m_cnt = 4'd0;
      m_cq  = 1'b0;
      e.y8  = 8'h00;
    end else begin
      if (c_in != m_cq && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
      m_cq = c_in;
      e.y8 = c_in ? 8'h3C : 8'hA5;
    end
    e.y1  = exp_y1;
    e.cnt = m_cnt;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: scoreboard empty, got y1=%b want an entry", tag, y1);
    end else begin
      e = sb.pop_front();
      tests++;
      assert (y1 === e.y1)
      else begin
        fails++;
        $error("FAIL %s y1: got %b want %b", e.tag, y1, e.y1);
      end
      tests++;
      assert (y8 === e.y8)
      else begin
        fails++;
        $error("FAIL %s y8: got %h want %h", e.tag, y8, e.y8);
      end
`ifdef MUX_2_SEL_CNT_EN
      tests++;
      assert (cnt1 === e.cnt)
      else begin
        fails++;
        $error("FAIL %s sel_cnt: got %0d want %0d", e.tag, cnt1, e.cnt);
      end
`endif
    end
  endtask

  initial begin
    m_cnt = 4'd0;
    m_cq  = 1'b0;
    truth = 8'b1101_1000;  // bit i = y for (a,b,c) = i
    rst_n = 1'b0;
    c     = 1'b0;
    a1    = 1'b0;
    b1    = 1'b0;
    a8    = 8'h00;
    b8    = 8'h00;

    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "reset0");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "reset1");

    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      for (int k = 0; k < 10; k++) begin
        step(abc[2], abc[1], abc[0], 1'b1, truth[i], $sformatf("exh%0d", i));
      end
    end

    // a1=0, b1=1 so y1 follows c; 20 toggles saturate the 4-bit counter.
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b1, ~c, 1'b1, ~c, $sformatf("toggle%0d", k));
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, c, 1'b1, c, $sformatf("hold%0d", k));
    end

    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "midrst");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "postrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
